alu_rs: RTL
===========

# alu_rs

Reservation station for the integer ALU functional unit in the out-of-order core. It accepts renamed ALU instructions (op_b_imm / op_b_reg) from dispatch, holds them until both physical source operands are ready, and tracks readiness by snooping CDB tag broadcasts. It issues one ready instruction per cycle to the ALU through a registered start/payload interface, honouring back-pressure from the CDB arbiter. It is the issue-side initiator of the ALU's start/valid protocol.

## Interface
- PHYS_REG_BITS, 6, physical register tag width
- ROB_IDX_BITS, 5, ROB index width
- NUM_ENTRIES, 8, station depth (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  synchronous squash of all entries and the issue register
- dispatch_valid  in  1  dispatch offers an instruction
- dispatch_ready  out  1  at least one free entry (from current valid bits only)
- dispatch_decode  in  decode_info_t  decoded instruction
- dispatch_ps1, dispatch_ps2, dispatch_pd  in  PHYS_REG_BITS each  source/dest tags
- dispatch_ps1_rdy, dispatch_ps2_rdy  in  1 each  source already written
- dispatch_rob_idx  in  ROB_IDX_BITS  ROB slot
- cdb_valid  in  1  result broadcast this cycle
- cdb_pd  in  PHYS_REG_BITS  broadcast tag
- fu_stall  in  1  ALU result not accepted this cycle; hold issue register
- issue_start  out  1  drives ALU start
- issue_decode  out  decode_info_t; issue_ps1, issue_ps2, issue_pd  out  PHYS_REG_BITS; issue_rob_idx  out  ROB_IDX_BITS  issued payload (regfile read tags and ALU decode)

## Operation
- Entry state: valid, ps1_rdy, ps2_rdy, decode, ps1, ps2, pd, rob_idx.
- Dispatch: fires when dispatch_valid && dispatch_ready && !flush; writes the lowest-index free entry.
- Readiness at dispatch: psN_rdy = dispatch_psN_rdy OR dispatch_psN == 0 OR (cdb_valid && cdb_pd == dispatch_psN); ps2_rdy additionally forced 1 when opcode == op_b_imm.
- Wakeup: every valid entry with psN == cdb_pd while cdb_valid sets psN_rdy. Tag 0 is never broadcast meaningfully; a match on 0 is harmless.
- Select: lowest-index entry with valid && ps1_rdy && ps2_rdy, using registered state only (no same-cycle wakeup-to-select).
- Issue register advance condition: adv = !issue_start || !fu_stall. When adv, load the selected entry (issue_start=1) and clear that entry's valid; if none selected, issue_start=0. When !adv, hold all issue outputs and do not select.
- An entry freed by select is not visible to dispatch_ready until the next cycle.
- flush: next cycle all valid=0, issue_start=0; dispatch and wakeup in the flush cycle are dropped.
- Reset: all valid=0, all ready bits 0, issue_start=0, issue payload 0, dispatch_ready=1.

## Timing
- Dispatch with both operands ready at cycle N: entry valid N+1, selected N+1, issue_start=1 in N+2.
- Wakeup at N for a resident entry: selectable N+1, issue_start N+2.
- Dispatch and matching CDB in the same cycle: bypassed, same latency as ready-at-dispatch.
- Throughput: one issue per cycle when fu_stall=0 and ready entries exist.
- fu_stall high for k cycles with issue_start=1: payload stable for k+1 cycles, no entries dequeued.
- Full station: dispatch_ready=0; simultaneous select does not re-enable it until the next cycle.
- Reset asserted mid-operation: outputs take reset values immediately (async), regardless of clk.

## Test plan
- Reset, dispatch ADDI x pd=7 ps1=3 ps1_rdy=1 rob=2 -> issue_start=1 two cycles later with issue_pd=7, issue_ps1=3, issue_rob_idx=2; dispatch_ready=1 throughout.
- Dispatch ADD ps1=5 (not ready), ps2=0 -> no issue; cdb_valid cdb_pd=5 at cycle N -> issue_start at N+2; same-cycle dispatch with cdb_pd=5 -> issues at dispatch+2.
- Fill 8 non-ready entries -> dispatch_ready=0 on cycle after 8th; wake entry 3 -> entry 3 issues, dispatch_ready=1 one cycle after select.
- Two ready entries, fu_stall=1 for 3 cycles -> first payload held 4 cycles, second issues the cycle after fu_stall drops.
- 4 valid entries, flush -> next cycle issue_start=0, dispatch_ready=1, no later issue even with matching CDB.
- Assert rst_n low between clock edges with issue_start=1 -> issue_start=0 before next edge; all entries empty after release.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: integer ALU reservation station.
// Holds renamed ALU ops until both sources are ready, then issues one per cycle.
package alu_rs_pkg;
    typedef enum logic [0:0] {
        op_b_reg = 1'b0,
        op_b_imm = 1'b1
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [3:0]  alu_fn;
        logic [11:0] imm;
    } decode_info_t;
endpackage

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int PHYS_REG_BITS = 6,
    parameter int ROB_IDX_BITS  = 5,
    parameter int NUM_ENTRIES   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  decode_info_t             dispatch_decode,
    input  logic [PHYS_REG_BITS-1:0] dispatch_ps1,
    input  logic [PHYS_REG_BITS-1:0] dispatch_ps2,
    input  logic [PHYS_REG_BITS-1:0] dispatch_pd,
    input  logic                     dispatch_ps1_rdy,
    input  logic                     dispatch_ps2_rdy,
    input  logic [ROB_IDX_BITS-1:0]  dispatch_rob_idx,
    input  logic                     cdb_valid,
    input  logic [PHYS_REG_BITS-1:0] cdb_pd,
    input  logic                     fu_stall,
    output logic                     issue_start,
    output decode_info_t             issue_decode,
    output logic [PHYS_REG_BITS-1:0] issue_ps1,
    output logic [PHYS_REG_BITS-1:0] issue_ps2,
    output logic [PHYS_REG_BITS-1:0] issue_pd,
    output logic [ROB_IDX_BITS-1:0]  issue_rob_idx
);

    localparam int IDX_BITS = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0]   valid;
    logic [NUM_ENTRIES-1:0]   ps1_rdy;
    logic [NUM_ENTRIES-1:0]   ps2_rdy;
    decode_info_t             decode_q [NUM_ENTRIES];
    logic [PHYS_REG_BITS-1:0] ps1_q    [NUM_ENTRIES];
    logic [PHYS_REG_BITS-1:0] ps2_q    [NUM_ENTRIES];
    logic [PHYS_REG_BITS-1:0] pd_q     [NUM_ENTRIES];
    logic [ROB_IDX_BITS-1:0]  rob_q    [NUM_ENTRIES];

    logic                alloc_found;
    logic [IDX_BITS-1:0] alloc_idx;
    logic                sel_found;
    logic [IDX_BITS-1:0] sel_idx;
    logic                fire;
    logic                adv;
    logic                do_issue;
    logic                new_ps1_rdy;
    logic                new_ps2_rdy;

    // Lowest-index free slot; dispatch_ready sees only registered valid bits.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_BITS'(i);
            end
        end
    end

    // Select uses registered ready bits: a wakeup is selectable next cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && ps1_rdy[i] && ps2_rdy[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_BITS'(i);
            end
        end
    end

    assign dispatch_ready = alloc_found;
    assign fire           = dispatch_valid && dispatch_ready && !flush;
    assign adv            = !issue_start || !fu_stall;
    assign do_issue       = adv && sel_found;

    assign new_ps1_rdy = dispatch_ps1_rdy
                      || (dispatch_ps1 == '0)
                      || (cdb_valid && (cdb_pd == dispatch_ps1));
    assign new_ps2_rdy = dispatch_ps2_rdy
                      || (dispatch_ps2 == '0)
                      || (cdb_valid && (cdb_pd == dispatch_ps2))
                      || (dispatch_decode.opcode == op_b_imm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= '0;
            ps1_rdy <= '0;
            ps2_rdy <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                decode_q[i] <= '0;
                ps1_q[i]    <= '0;
                ps2_q[i]    <= '0;
                pd_q[i]     <= '0;
                rob_q[i]    <= '0;
            end
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (valid[i] && cdb_valid && (ps1_q[i] == cdb_pd))
                    ps1_rdy[i] <= 1'b1;
                if (valid[i] && cdb_valid && (ps2_q[i] == cdb_pd))
                    ps2_rdy[i] <= 1'b1;
            end
            if (do_issue)
                valid[sel_idx] <= 1'b0;
            // Alloc slot is free, so it never collides with the selected one.
            if (fire) begin
                valid[alloc_idx]    <= 1'b1;
                ps1_rdy[alloc_idx]  <= new_ps1_rdy;
                ps2_rdy[alloc_idx]  <= new_ps2_rdy;
                decode_q[alloc_idx] <= dispatch_decode;
                ps1_q[alloc_idx]    <= dispatch_ps1;
                ps2_q[alloc_idx]    <= dispatch_ps2;
                pd_q[alloc_idx]     <= dispatch_pd;
                rob_q[alloc_idx]    <= dispatch_rob_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_start   <= 1'b0;
            issue_decode  <= '0;
            issue_ps1     <= '0;
            issue_ps2     <= '0;
            issue_pd      <= '0;
            issue_rob_idx <= '0;
        end else if (flush) begin
            issue_start <= 1'b0;
        end else if (adv) begin
            issue_start <= sel_found;
            if (sel_found) begin
                issue_decode  <= decode_q[sel_idx];
                issue_ps1     <= ps1_q[sel_idx];
                issue_ps2     <= ps2_q[sel_idx];
                issue_pd      <= pd_q[sel_idx];
                issue_rob_idx <= rob_q[sel_idx];
            end
        end
    end

endmodule
